pl_id_ex_reg: RTL and testbench
===============================

Name: pl_id_ex_reg

Overview:
ID/EX pipeline register of the 5-stage MIPS pipeline. It captures decoded control and operand fields each cycle and is the consumer of the load-use stall request from hazard detection: on `nop` it inserts a bubble into EX. Its registered `ex_mem_read` and `ex_rt` are the ID_EX_mem_read / ID_EX_rt fed back to hazard detection. It also supports pipeline hold (whole pipe frozen) and branch flush.

Parameters:
- DATA_W, 32, width of PC+4, register operands and immediate.
- ALU_OP_W, 2, width of the ALU-op control field.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- hold  in  1  freeze: the register keeps its contents.
- nop  in  1  load-use bubble request from hazard detection.
- flush  in  1  branch-taken flush of the instruction in ID.
- id_valid  in  1  ID holds a real instruction.
- id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_alu_src, id_reg_dst, id_branch  in  1 each  decoded controls.
- id_alu_op  in  ALU_OP_W  ALU-op class.
- id_pc_plus4, id_rd1, id_rd2, id_imm  in  DATA_W each  PC+4, rs data, rt data, sign-extended immediate.
- id_rs, id_rt, id_rd  in  5 each  register specifiers.
- id_funct  in  6  function field.
- ex_valid  out  1  EX holds a real instruction.
- ex_reg_write … ex_branch, ex_alu_op  out  same widths  registered controls.
- ex_pc_plus4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct  out  same widths  registered data.

Behaviour:
- One register stage: ID inputs at edge N appear on ex_* after edge N, i.e. latency 1. No combinational path from input to output.
- Reset (async assert, sync-to-clk release irrelevant; acts immediately):
  - every output is 0, including ex_valid, all controls, all data and all specifiers.
- Priority per rising edge: rst > flush > hold > nop > normal load.
- flush=1:
  - ex_valid and all control outputs (reg_write, mem_to_reg, mem_read, mem_write, alu_src, reg_dst, branch, alu_op) become 0.
  - Data and specifier outputs retain their previous values.
  - Flush overrides hold.
- hold=1 (flush=0):
  - All outputs retain their values; nop is ignored.
  - A held load keeps ex_mem_read=1, so hazard detection keeps stalling consistently.
- nop=1 (flush=0, hold=0) — bubble:
  - ex_valid and all controls become 0.
  - Data and specifier fields capture the ID inputs normally; they are don't-care content, captured deterministically.
  - Because ex_mem_read=0 after a bubble, nop cannot repeat for the same pair.
- Normal (all 0):
  - All fields load from ID.
  - ex_valid = id_valid.
  - If id_valid=0, the controls are forced to 0 regardless of the id_* control values.
- Reset asserted mid-operation clears everything on assertion; the first edge after deassert loads per the priority rules.
- Simultaneous nop+flush: treated as flush (identical control result; data retained, not loaded).

Optional Feature:
- Macro PL_ID_EX_STATS_EN.
- Defined: adds outputs `bubble_count` and `flush_count`, each 32-bit and wrapping at 2^32.
  - `bubble_count` increments on each edge where nop is taken (nop=1, hold=0, flush=0).
  - `flush_count` increments on each edge where flush=1.
  - Both counters are cleared by rst and frozen by nothing else.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert rst mid-cycle with random ex_* contents -> all outputs 0 immediately, before the next edge; deassert; load id_rt=5 with id_mem_read=1 and id_valid=1 -> next edge ex_rt=5, ex_mem_read=1, ex_valid=1.
- Load-use bubble: load lw (mem_read=1, rt=8), then an add with nop=1 -> ex_valid=0, all controls 0, ex_rt = add's rt; next edge with nop=0 loads add normally, ex_reg_write=1.
- Hold: ex holds lw (rt=8); hold=1 for 3 cycles with changing id_* and nop=1 -> outputs unchanged for 3 cycles, ex_mem_read stays 1.
- Flush during hold: hold=1, flush=1 -> ex_valid=0, controls 0, ex_rd1 unchanged from prior value (e.g. 0xDEADBEEF).
- Invalid ID: id_valid=0 with id_reg_write=1, id_mem_write=1 -> ex_valid=0, ex_reg_write=0, ex_mem_write=0.
- PL_ID_EX_STATS_EN: 4 bubbles, 2 flushes, 1 nop+flush, 1 nop-during-hold -> bubble_count=4, flush_count=3; rst -> both 0.

Source files
------------

// File: rtl/pl_id_ex_reg.sv
// ID/EX pipeline register: captures decoded controls and operands, inserts bubbles on nop,
// freezes on hold and squashes on flush. Optional PL_ID_EX_STATS_EN adds bubble/flush counters.
module pl_id_ex_reg #(
    parameter int DATA_W   = 32,
    parameter int ALU_OP_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hold,
    input  logic                nop,
    input  logic                flush,
    input  logic                id_valid,
    input  logic                id_reg_write,
    input  logic                id_mem_to_reg,
    input  logic                id_mem_read,
    input  logic                id_mem_write,
    input  logic                id_alu_src,
    input  logic                id_reg_dst,
    input  logic                id_branch,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic [DATA_W-1:0]   id_pc_plus4,
    input  logic [DATA_W-1:0]   id_rd1,
    input  logic [DATA_W-1:0]   id_rd2,
    input  logic [DATA_W-1:0]   id_imm,
    input  logic [4:0]          id_rs,
    input  logic [4:0]          id_rt,
    input  logic [4:0]          id_rd,
    input  logic [5:0]          id_funct,
    output logic                ex_valid,
    output logic                ex_reg_write,
    output logic                ex_mem_to_reg,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic                ex_alu_src,
    output logic                ex_reg_dst,
    output logic                ex_branch,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic [DATA_W-1:0]   ex_pc_plus4,
    output logic [DATA_W-1:0]   ex_rd1,
    output logic [DATA_W-1:0]   ex_rd2,
    output logic [DATA_W-1:0]   ex_imm,
    output logic [4:0]          ex_rs,
    output logic [4:0]          ex_rt,
    output logic [4:0]          ex_rd,
    output logic [5:0]          ex_funct
`ifdef PL_ID_EX_STATS_EN
    ,
    output logic [31:0]         bubble_count,
    output logic [31:0]         flush_count
`endif
);

    localparam int CW = 7 + ALU_OP_W;

    logic [CW-1:0] id_ctrl;
    logic [CW-1:0] ctrl_q;
    logic          valid_q;
    logic          take;

    assign id_ctrl = {id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write,
                      id_alu_src, id_reg_dst, id_branch, id_alu_op};

    // A bubble or an empty ID slot both present as an all-zero control word to EX.
    assign take = id_valid & ~nop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (!hold) begin
            valid_q <= take;
            ctrl_q  <= take ? id_ctrl : '0;
        end
    end

    // Operand fields are loaded on bubbles too, but kept across flush and hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_pc_plus4 <= '0;
            ex_rd1      <= '0;
            ex_rd2      <= '0;
            ex_imm      <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_funct    <= '0;
        end else if (!flush && !hold) begin
            ex_pc_plus4 <= id_pc_plus4;
            ex_rd1      <= id_rd1;
            ex_rd2      <= id_rd2;
            ex_imm      <= id_imm;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_rd       <= id_rd;
            ex_funct    <= id_funct;
        end
    end

    assign ex_valid = valid_q;
    assign {ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
            ex_alu_src, ex_reg_dst, ex_branch, ex_alu_op} = ctrl_q;

`ifdef PL_ID_EX_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_count <= '0;
            flush_count  <= '0;
        end else begin
            if (flush)
                flush_count <= flush_count + 32'd1;
            if (nop && !hold && !flush)
                bubble_count <= bubble_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pl_id_ex_reg.sv
// Randomized and directed bench for pl_id_ex_reg against a field-level behavioural model.
module tb_pl_id_ex_reg;

  typedef struct packed {
    logic        valid;
    logic [6:0]  ctrl;
    logic [1:0]  alu_op;
    logic [31:0] pc4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [31:0] bub;
    logic [31:0] fl;
  } snap_t;

  logic clk = 1'b0;
  logic rst, hold, nop, flush, id_valid;
  logic [6:0]  id_ctrl;
  logic [1:0]  id_alu_op;
  logic [31:0] id_pc_plus4, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [5:0]  id_funct;

  logic ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;
  logic ex_alu_src, ex_reg_dst, ex_branch;
  logic [1:0]  ex_alu_op;
  logic [31:0] ex_pc_plus4, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [5:0]  ex_funct;
  logic [31:0] dut_bub, dut_fl;

  int total = 0;
  int bad = 0;
  snap_t m;
  snap_t dut_s;
  logic [$bits(snap_t)-1:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  pl_id_ex_reg #(.DATA_W(32), .ALU_OP_W(2)) dut (
    .clk(clk), .rst(rst), .hold(hold), .nop(nop), .flush(flush), .id_valid(id_valid),
    .id_reg_write(id_ctrl[6]), .id_mem_to_reg(id_ctrl[5]), .id_mem_read(id_ctrl[4]),
    .id_mem_write(id_ctrl[3]), .id_alu_src(id_ctrl[2]), .id_reg_dst(id_ctrl[1]),
    .id_branch(id_ctrl[0]), .id_alu_op(id_alu_op),
    .id_pc_plus4(id_pc_plus4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
    .ex_reg_dst(ex_reg_dst), .ex_branch(ex_branch), .ex_alu_op(ex_alu_op),
    .ex_pc_plus4(ex_pc_plus4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct)
`ifdef PL_ID_EX_STATS_EN
    , .bubble_count(dut_bub), .flush_count(dut_fl)
`endif
  );

`ifndef PL_ID_EX_STATS_EN
  assign dut_bub = 32'd0;
  assign dut_fl  = 32'd0;
`endif

  assign dut_s = {ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
                  ex_alu_src, ex_reg_dst, ex_branch, ex_alu_op,
                  ex_pc_plus4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct,
                  dut_bub, dut_fl};

  // behavioural model: what EX must show after each edge, from the priority rules
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m = '0;
      exp_q.delete();
      exp_q.push_back(m);
    end else begin
      if (flush) begin
        m.valid  = 1'b0;
        m.ctrl   = '0;
        m.alu_op = '0;
`ifdef PL_ID_EX_STATS_EN
        m.fl = m.fl + 32'd1;
`endif
      end else if (!hold) begin
        m.pc4 = id_pc_plus4; m.rd1 = id_rd1; m.rd2 = id_rd2; m.imm = id_imm;
        m.rs = id_rs; m.rt = id_rt; m.rd = id_rd; m.funct = id_funct;
        if (nop || !id_valid) begin
          m.valid = 1'b0; m.ctrl = '0; m.alu_op = '0;
        end else begin
          m.valid = 1'b1; m.ctrl = id_ctrl; m.alu_op = id_alu_op;
        end
`ifdef PL_ID_EX_STATS_EN
        if (nop) m.bub = m.bub + 32'd1;
`endif
      end
      exp_q.push_back(m);
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    logic [$bits(snap_t)-1:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL cycle_cmp: no expectation queued at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      if (dut_s !== e) begin
        bad++;
        $display("FAIL cycle_cmp at %0t: got %h want %h", $time, dut_s, e);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rand_id();
    id_valid    = ($urandom_range(0, 3) != 0);
    id_ctrl     = 7'($urandom);
    id_alu_op   = 2'($urandom);
    id_pc_plus4 = $urandom;
    id_rd1      = $urandom;
    id_rd2      = $urandom;
    id_imm      = $urandom;
    id_rs       = 5'($urandom);
    id_rt       = 5'($urandom);
    id_rd       = 5'($urandom);
    id_funct    = 6'($urandom);
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; nop = 1'b0; flush = 1'b0;
    rand_id();
    repeat (3) step();
    rst = 1'b0;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      hold  = ($urandom_range(0, 4) == 0);
      nop   = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 6) == 0);
      rand_id();
      step();
    end

    // reset asserted mid-cycle clears outputs before the next edge
    hold = 1'b0; nop = 1'b0; flush = 1'b0;
    rand_id();
    id_valid = 1'b1; id_ctrl = 7'b1111111; id_rd1 = 32'h1234_5678; id_funct = 6'h2a;
    step();
    #1 rst = 1'b1;
    #1;
    chk("rst_async_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_async_regw", {31'd0, ex_reg_write}, 32'd0);
    chk("rst_async_rd1", ex_rd1, 32'd0);
    chk("rst_async_funct", {26'd0, ex_funct}, 32'd0);
    step();
    rst = 1'b0;
    rand_id();
    id_valid = 1'b1; id_ctrl = 7'b0010100; id_rt = 5'd5;
    step();
    chk("post_rst_rt", {27'd0, ex_rt}, 32'd5);
    chk("post_rst_memrd", {31'd0, ex_mem_read}, 32'd1);
    chk("post_rst_valid", {31'd0, ex_valid}, 32'd1);

    // load-use bubble
    id_valid = 1'b1; id_ctrl = 7'b1110100; id_rt = 5'd8;
    step();
    id_ctrl = 7'b1000010; id_rt = 5'd9; id_alu_op = 2'b10; nop = 1'b1;
    step();
    chk("bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("bubble_ctrl", {23'd0, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
                        ex_alu_src, ex_reg_dst, ex_branch, ex_alu_op}, 32'd0);
    chk("bubble_rt", {27'd0, ex_rt}, 32'd9);
    nop = 1'b0;
    step();
    chk("after_bubble_regw", {31'd0, ex_reg_write}, 32'd1);
    chk("after_bubble_valid", {31'd0, ex_valid}, 32'd1);

    // hold keeps a load in EX, nop ignored
    id_ctrl = 7'b1110100; id_rt = 5'd8; id_rd1 = 32'hDEAD_BEEF;
    step();
    hold = 1'b1; nop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      step();
      chk("hold_rt", {27'd0, ex_rt}, 32'd8);
      chk("hold_memrd", {31'd0, ex_mem_read}, 32'd1);
      chk("hold_rd1", ex_rd1, 32'hDEAD_BEEF);
      chk("hold_valid", {31'd0, ex_valid}, 32'd1);
    end

    // flush wins over hold; data kept
    flush = 1'b1;
    step();
    chk("flush_hold_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_hold_memrd", {31'd0, ex_mem_read}, 32'd0);
    chk("flush_hold_rd1", ex_rd1, 32'hDEAD_BEEF);
    flush = 1'b0; hold = 1'b0; nop = 1'b0;

    // invalid ID forces controls low
    id_valid = 1'b0; id_ctrl = 7'b1001000;
    step();
    chk("inv_valid", {31'd0, ex_valid}, 32'd0);
    chk("inv_regw", {31'd0, ex_reg_write}, 32'd0);
    chk("inv_memw", {31'd0, ex_mem_write}, 32'd0);

    // counter sequence: 4 bubbles, 2 flushes, 1 nop+flush, 1 nop during hold
    rst = 1'b1;
    step();
    rst = 1'b0;
    rand_id();
    nop = 1'b1;
    repeat (4) step();
    nop = 1'b0; flush = 1'b1;
    repeat (2) step();
    nop = 1'b1;
    step();
    flush = 1'b0; hold = 1'b1;
    step();
    hold = 1'b0; nop = 1'b0;
`ifdef PL_ID_EX_STATS_EN
    chk("bubble_count", dut_bub, 32'd4);
    chk("flush_count", dut_fl, 32'd3);
    rst = 1'b1;
    step();
    chk("bubble_count_rst", dut_bub, 32'd0);
    chk("flush_count_rst", dut_fl, 32'd0);
    rst = 1'b0;
`endif
    repeat (2) step();

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
